// File: rtl/pushbtn_pkg.sv
// -----------------------------------------------------------------------------
// pushbtn_pkg
// Shared types and defaults for the push-button debouncer.
//   db_state_t         : per-channel debounce FSM state encoding
//   DB_CYCLES_DEFAULT  : default debounce window (20 ms at 50 MHz)
// -----------------------------------------------------------------------------
package pushbtn_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    localparam int DB_CYCLES_DEFAULT = 1000000;

endpackage : pushbtn_pkg

// File: rtl/pushbtn_db_channel.sv
// -----------------------------------------------------------------------------
// pushbtn_db_channel
// One push-button channel: synchroniser, debounce FSM with stability counter,
// one-cycle press/release pulses and a software-cleared sticky press latch.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   btn_raw_i      : asynchronous raw button pin, active-high
//   sticky_clr_i   : clear strobe for the sticky latch
//   level_o        : debounced level
//   press_o        : one-cycle pulse on a debounced 0->1
//   release_o      : one-cycle pulse on a debounced 1->0
//   sticky_o       : set by a press, held until cleared
// -----------------------------------------------------------------------------
module pushbtn_db_channel
    import pushbtn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    input  logic sticky_clr_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic sticky_o
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sticky_q, sticky_d;

    // Plain shift chain; nothing may sit between the stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter holds the number of consecutive samples of the new value,
    // so acceptance happens on the (DB_CYCLES+1)-th one and cnt never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d   = STABLE_HI;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = STABLE_LO;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // Set takes priority over a coincident clear.
        sticky_d = press_d | (sticky_q & ~sticky_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            sticky_q  <= sticky_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign sticky_o  = sticky_q;

endmodule : pushbtn_db_channel

// File: rtl/pushbtn_debouncer.sv
// -----------------------------------------------------------------------------
// pushbtn_debouncer
// Conditions N_BTN raw push-buttons for the system controller and raises a
// maskable interrupt from the sticky press latches.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_btn_raw       : asynchronous raw button pins, active-high
//   i_sticky_clr    : write-1-to-clear strobe for o_press_sticky
//   i_irq_mask      : per-button interrupt enable
//   o_btn_level     : debounced levels
//   o_btn_press     : one-cycle press pulses
//   o_btn_release   : one-cycle release pulses
//   o_press_sticky  : sticky press latches
//   o_irq           : registered OR of (o_press_sticky & i_irq_mask)
// -----------------------------------------------------------------------------
module pushbtn_debouncer
    import pushbtn_pkg::*;
#(
    parameter int N_BTN       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic [N_BTN-1:0] i_sticky_clr,
    input  logic [N_BTN-1:0] i_irq_mask,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release,
    output logic [N_BTN-1:0] o_press_sticky,
    output logic             o_irq
);

    logic irq_q, irq_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        pushbtn_db_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_chan (
            .clk_i        (i_clk),
            .rst_i        (i_rst),
            .btn_raw_i    (i_btn_raw[g]),
            .sticky_clr_i (i_sticky_clr[g]),
            .level_o      (o_btn_level[g]),
            .press_o      (o_btn_press[g]),
            .release_o    (o_btn_release[g]),
            .sticky_o     (o_press_sticky[g])
        );
    end

    assign irq_d = |(o_press_sticky & i_irq_mask);

    always_ff @(posedge i_clk) begin
        if (i_rst) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign o_irq = irq_q;

endmodule : pushbtn_debouncer

// File: tb/tb_pushbtn_debouncer.sv
// -----------------------------------------------------------------------------
// tb_pushbtn_debouncer
// Self-checking bench for pushbtn_debouncer with DB_CYCLES=4, SYNC_STAGES=2.
// -----------------------------------------------------------------------------
module tb_pushbtn_debouncer;

    localparam int NB = 5;
    localparam int SS = 2;
    localparam int DB = 4;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] stk;
        logic          irq;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [NB-1:0] i_btn_raw = '0;
    logic [NB-1:0] i_sticky_clr = '0;
    logic [NB-1:0] i_irq_mask = '0;
    logic [NB-1:0] o_btn_level, o_btn_press, o_btn_release, o_press_sticky;
    logic          o_irq;

    pushbtn_debouncer #(.N_BTN(NB), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_btn_raw      (i_btn_raw),
        .i_sticky_clr   (i_sticky_clr),
        .i_irq_mask     (i_irq_mask),
        .o_btn_level    (o_btn_level),
        .o_btn_press    (o_btn_press),
        .o_btn_release  (o_btn_release),
        .o_press_sticky (o_press_sticky),
        .o_irq          (o_irq)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ecount   = 0;
    int   base     = 0;
    int   press_cnt [NB];
    int   rel_cnt   [NB];
    int   press_edge[NB];
    int   rel_edge  [NB];
    exp_t sb_q[$];

    // Reference model: a change is taken once DB+1 consecutive samples at the
    // synchroniser output differ from the current debounced level.
    logic [SS-1:0] m_sync [NB];
    int            m_run  [NB];
    logic [NB-1:0] m_lvl, m_prs, m_rel, m_stk;
    logic          m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, ecount, obs, exp);
        end
    endtask

    task automatic model_step();
        logic s;
        if (i_rst) begin
            for (int c = 0; c < NB; c++) begin
                m_sync[c] = '0;
                m_run[c]  = 0;
            end
            m_lvl = '0; m_prs = '0; m_rel = '0; m_stk = '0; m_irq = 1'b0;
        end else begin
            m_irq = |(m_stk & i_irq_mask);
            m_prs = '0;
            m_rel = '0;
            for (int c = 0; c < NB; c++) begin
                s = m_sync[c][SS-1];
                m_sync[c] = {m_sync[c][SS-2:0], i_btn_raw[c]};
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_lvl[c] = s;
                        if (s) m_prs[c] = 1'b1;
                        else   m_rel[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_stk = m_prs | (m_stk & ~i_sticky_clr);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        sb_q.push_back('{lvl: m_lvl, prs: m_prs, rel: m_rel, stk: m_stk, irq: m_irq});
        @(posedge i_clk);
        #1;
        ecount++;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_level",   o_btn_level,    e.lvl);
            chk("sb_press",   o_btn_press,    e.prs);
            chk("sb_release", o_btn_release,  e.rel);
            chk("sb_sticky",  o_press_sticky, e.stk);
            chk("sb_irq",     o_irq,          e.irq);
        end
        for (int c = 0; c < NB; c++) begin
            if (o_btn_press[c])   begin press_cnt[c]++; press_edge[c] = ecount - base; end
            if (o_btn_release[c]) begin rel_cnt[c]++;   rel_edge[c]   = ecount - base; end
        end
    endtask

    task automatic clr_stats();
        base = ecount;
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; press_edge[c] = -1; rel_edge[c] = -1;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_btn_raw = '0; i_sticky_clr = '0;
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_stats();
        // Reset state
        do_reset();
        chk("rst_outputs", {o_btn_level, o_btn_press, o_btn_release, o_press_sticky, o_irq}, 0);

        // 1: clean press on channel 0
        i_irq_mask = 5'b11111;
        i_btn_raw  = 5'b00001;
        clr_stats();
        repeat (6) tick();
        chk("s1_level_e6", o_btn_level[0], 0);
        tick();
        chk("s1_level_e7",  o_btn_level[0],    1);
        chk("s1_press_e7",  o_btn_press[0],    1);
        chk("s1_sticky_e7", o_press_sticky[0], 1);
        tick();
        chk("s1_press_e8", o_btn_press[0], 0);
        chk("s1_irq_e8",   o_irq,          1);
        chk("s1_press_cnt", press_cnt[0],  1);

        // 2: 4-cycle glitch rejected, 5-cycle press accepted
        do_reset();
        i_btn_raw = 5'b00010;
        clr_stats();
        repeat (4) tick();
        i_btn_raw = '0;
        repeat (12) tick();
        chk("s2_short_press_cnt", press_cnt[1], 0);
        chk("s2_short_rel_cnt",   rel_cnt[1],   0);
        chk("s2_short_level",     o_btn_level[1], 0);
        clr_stats();
        i_btn_raw = 5'b00010;
        repeat (5) tick();
        i_btn_raw = '0;
        repeat (12) tick();
        chk("s2_press_cnt",  press_cnt[1],  1);
        chk("s2_press_edge", press_edge[1], 7);
        chk("s2_rel_cnt",    rel_cnt[1],    1);
        chk("s2_rel_edge",   rel_edge[1],   12);

        // 3: bouncing contact on channel 2
        do_reset();
        clr_stats();
        for (int i = 0; i < 5; i++) begin
            i_btn_raw[2] = (i % 2 == 0);
            tick();
        end
        i_btn_raw[2] = 1'b1;
        repeat (12) tick();
        chk("s3_press_cnt",  press_cnt[2],  1);
        chk("s3_press_edge", press_edge[2], 11);

        // 4: sticky, irq mask and clear priority on channel 3
        do_reset();
        i_irq_mask = 5'b01000;
        i_btn_raw  = 5'b01000;
        clr_stats();
        repeat (7) tick();
        chk("s4_sticky_e7", o_press_sticky[3], 1);
        chk("s4_irq_e7",    o_irq,             0);
        tick();
        chk("s4_irq_e8", o_irq, 1);
        i_btn_raw = '0;
        repeat (8) tick();
        i_btn_raw = 5'b01000;
        repeat (6) tick();
        i_sticky_clr = 5'b01000;
        tick();
        chk("s4_press_with_clr",  o_btn_press[3],    1);
        chk("s4_sticky_set_wins", o_press_sticky[3], 1);
        chk("s4_press_edge",      press_edge[3],     23);
        i_sticky_clr = '0;
        repeat (2) tick();
        i_sticky_clr = 5'b01000;
        tick();
        chk("s4_sticky_cleared", o_press_sticky[3], 0);
        chk("s4_irq_still_set",  o_irq,             1);
        chk("s4_level_kept",     o_btn_level[3],    1);
        i_sticky_clr = '0;
        tick();
        chk("s4_irq_cleared", o_irq, 0);

        // 5: all channels pressed together
        do_reset();
        i_btn_raw = 5'b11111;
        repeat (6) tick();
        chk("s5_press_e6", o_btn_press, 5'b00000);
        tick();
        chk("s5_press_e7", o_btn_press, 5'b11111);
        chk("s5_level_e7", o_btn_level, 5'b11111);
        tick();
        chk("s5_press_e8", o_btn_press, 5'b00000);

        // 6: reset mid-window with the button held, then fresh press
        do_reset();
        i_btn_raw = 5'b00001;
        clr_stats();
        repeat (5) tick();
        i_rst = 1'b1;
        tick();
        chk("s6_rst_outputs", {o_btn_level, o_btn_press, o_btn_release, o_press_sticky, o_irq}, 0);
        chk("s6_no_pulse_rst", press_cnt[0], 0);
        i_rst = 1'b0;
        clr_stats();
        repeat (6) tick();
        chk("s6_press_cnt_e6", press_cnt[0], 0);
        tick();
        chk("s6_press_e7",   o_btn_press[0], 1);
        chk("s6_press_edge", press_edge[0],  7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pushbtn_debouncer

// File: doc/pushbtn_debouncer.md
Name: pushbtn_debouncer

Overview:
Conditions the raw board push-buttons before the system controller reads them. The system controller exposes the button status word at offset 0x1C.
Per button, the block provides:
- a synchroniser
- a debounce FSM with a stability counter
- one-cycle press/release pulses
- a sticky press latch that software clears
The block also raises a maskable interrupt request that the system controller can route to a software IRQ line.

Parameters:
N_BTN, 5, number of button channels
SYNC_STAGES, 2, flip-flop synchroniser depth; minimum 2
DB_CYCLES, 1000000, debounce window in i_clk cycles; 20 ms at 50 MHz; minimum 1
CNT_W, $clog2(DB_CYCLES+1), counter width; derived, never overridden

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_btn_raw  in  N_BTN  asynchronous raw button pins, active-high
i_sticky_clr  in  N_BTN  write-1-to-clear strobe for o_press_sticky; one cycle wide
i_irq_mask  in  N_BTN  per-button interrupt enable
o_btn_level  out  N_BTN  debounced level; drives the system controller's push_btn input
o_btn_press  out  N_BTN  one-cycle pulse on each debounced 0->1 transition
o_btn_release  out  N_BTN  one-cycle pulse on each debounced 1->0 transition
o_press_sticky  out  N_BTN  set by a press, held until cleared
o_irq  out  1  registered OR-reduction of (o_press_sticky & i_irq_mask)

Behaviour:
- Reset state:
  - All outputs 0.
  - Synchroniser flops 0.
  - Every channel FSM in STABLE_LO with counter 0.
  - Reset applied mid-debounce abandons the window without emitting a pulse.
- Synchroniser: SYNC_STAGES flops in series. s = last stage. No logic between stages.
- Per-channel FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- From STABLE_LO:
  - s=1 -> WAIT_HI, cnt<=1.
  - Otherwise hold, cnt<=0.
- From WAIT_HI:
  - s=0 -> STABLE_LO, cnt<=0 (bounce rejected, no pulse).
  - s=1 and cnt==DB_CYCLES -> STABLE_HI, level<=1, press pulse<=1.
  - Otherwise cnt<=cnt+1.
- STABLE_HI and WAIT_LO mirror the above with s inverted. The transition sets level<=0 and release pulse<=1.
- Acceptance and rejection:
  - A change is accepted only after DB_CYCLES+1 consecutive cycles of the new value at s.
  - Any excursion at s lasting DB_CYCLES cycles or fewer is rejected.
- Latency: o_btn_level changes exactly SYNC_STAGES+DB_CYCLES clock edges after the first edge that samples the new raw value.
- Counter rules: cnt never exceeds DB_CYCLES, so it never wraps. Width is CNT_W.
- Pulses:
  - o_btn_press and o_btn_release are registered and high for exactly one cycle.
  - They are never both high on the same channel in the same cycle.
- Sticky latch:
  - Set on o_btn_press, in the same cycle the pulse is asserted.
  - Cleared on the cycle after i_sticky_clr is sampled high.
  - If a set and a clear coincide, the set wins.
  - Clear has no effect on the other outputs.
- o_irq:
  - Registered, one cycle after the sticky/mask change.
  - Mask changes take effect one cycle later without altering sticky state.
- Independence: channels are fully independent. Simultaneous presses on several channels each produce their own pulse.
- Held through reset: a button held while i_rst deasserts is treated as a fresh press. It yields WAIT_HI, then a press pulse after the full latency.
- DB_CYCLES=1: a new value must persist for 2 cycles at s.

Decomposition:
- Package pushbtn_pkg holds:
  - the enum db_state_t {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} as 2 bits
  - a localparam with the default DB_CYCLES
- Sub-module pushbtn_db_channel (one button) contains:
  - the synchroniser, FSM, counter, pulse, and sticky logic
- The top level generates N_BTN instances and the o_irq reduction register.

Test Plan:
All scenarios use DB_CYCLES=4 and SYNC_STAGES=2.
1. Reset, then raw[0] rises before edge 1 and is held -> o_btn_level[0]=1 after edge 7. o_btn_press[0] high exactly one cycle, at edge 7. o_press_sticky[0]=1 from the same edge.
2. Raw[1] high for exactly 4 cycles, then low -> no level change, no pulses. Repeat with 5 cycles -> press pulse observed, then a release pulse 6 cycles after the fall is sampled.
3. Raw[2] bounces 1,0,1,0,1 on consecutive cycles, then holds high -> exactly one press pulse. It occurs 6 edges after the last rising sample.
4. Sticky[3] set with i_irq_mask=5'b01000 -> o_irq=1 one cycle later. Pulse i_sticky_clr[3] on the same cycle as a new press on channel 3 -> sticky stays 1. Clear alone -> sticky 0, then o_irq 0 one cycle later.
5. Presses on all 5 channels in the same cycle -> o_btn_press=5'b11111 for one cycle. o_btn_level=5'b11111.
6. Assert i_rst during WAIT_HI at cnt=3 while raw is held high -> all outputs 0. After release, press pulse 6 edges after the first post-reset sampling edge.
